// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel gradient datapath.
// Window layout is [row][col] with row 0 on top and col 0 the right-most pixel.
package sobel_pkg;

    typedef logic [7:0] pixel_t;
    typedef pixel_t [2:0][2:0] window_t;
    typedef logic signed [10:0] grad_t;

    localparam pixel_t PIX_MAX = 8'd255;

    // a + 2b + c for one kernel column/row; the maximum of 1020 fits in 10 bits.
    function automatic logic [9:0] weighted_sum(input pixel_t a, input pixel_t b, input pixel_t c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [9:0] abs_grad(input grad_t g);
        grad_t neg;
        neg = -g;
        return g[10] ? neg[9:0] : g[9:0];
    endfunction

endpackage

// File: rtl/sobel_out_fifo.sv
// Small synchronous FIFO buffering edge pixels toward the output writer.
// Pointers wrap naturally because the depth is a power of two.
module sobel_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sobel_gradient.sv
// Three-stage Sobel magnitude pipeline feeding an output FIFO.
// Upstream is throttled by a credit check so the pipeline itself never stalls.
module sobel_gradient
    import sobel_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  window_t          sobel_matrix,
    input  logic             sobel_ready,
    input  logic             thresh_en,
    input  logic [7:0]       threshold,
    output logic             calc_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] pixel_count,
    output logic             overflow
);

    localparam int CW = $clog2(FIFO_DEPTH);

    logic            accept;
    logic            v1;
    logic            v2;
    grad_t           gx_q;
    grad_t           gy_q;
    logic            ten1;
    logic            ten2;
    pixel_t          thr1;
    pixel_t          thr2;
    logic [10:0]     mag_q;
    pixel_t          pix;
    logic            pop;
    logic [CW:0]     fifo_count;
    logic [CW+1:0]   credit_sum;
    logic            fifo_empty;
    logic            fifo_full;
    pixel_t          fifo_head;
    logic            unused_center;

    // The centre pixel has zero weight in both kernels.
    assign unused_center = ^sobel_matrix[1][1];

    assign credit_sum = {1'b0, fifo_count} + (CW+2)'(v1) + (CW+2)'(v2);
    assign calc_busy  = credit_sum >= (CW+2)'(FIFO_DEPTH);
    assign accept     = sobel_ready & ~calc_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= accept;
            v2 <= v1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            gx_q <= $signed({1'b0, weighted_sum(sobel_matrix[0][0], sobel_matrix[1][0], sobel_matrix[2][0])})
                  - $signed({1'b0, weighted_sum(sobel_matrix[0][2], sobel_matrix[1][2], sobel_matrix[2][2])});
            gy_q <= $signed({1'b0, weighted_sum(sobel_matrix[2][0], sobel_matrix[2][1], sobel_matrix[2][2])})
                  - $signed({1'b0, weighted_sum(sobel_matrix[0][0], sobel_matrix[0][1], sobel_matrix[0][2])});
            ten1 <= thresh_en;
            thr1 <= threshold;
        end
        mag_q <= {1'b0, abs_grad(gx_q)} + {1'b0, abs_grad(gy_q)};
        ten2  <= ten1;
        thr2  <= thr1;
    end

    always_comb begin
        pix = mag_q[7:0];
        if (ten2) begin
            pix = (mag_q >= {3'b000, thr2}) ? PIX_MAX : 8'd0;
        end else if (mag_q > 11'd255) begin
            pix = PIX_MAX;
        end
    end

    assign pop       = out_valid & out_ready;
    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? 8'd0 : fifo_head;

    sobel_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (v2 & ~fifo_full),
        .pop     (pop),
        .wr_data (pix),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (pop) pixel_count <= pixel_count + 1'b1;
            if (sobel_ready && calc_busy) overflow <= 1'b1;
        end
    end

endmodule
